vga_border_gen: RTL and testbench

- Self-contained VGA scan generator plus configurable border ("wall") renderer for the Wild Cube display path.
- Parametrised successor of the fixed blue-wall block: timing generalised per resolution, wall thickness runtime-loadable, wall identity reported per side, blink and chase display modes.
- Sits between the clock-enable divider and the colour mux. The mux paints wall pixels blue and uses x/y/active for the playfield.

---
 rtl/vga_border_gen.sv | 200 ++++++++++++++++++++
 tb/tb_vga_border_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_border_gen.sv
// VGA scan generator with a runtime-configurable border renderer.
// The wall thickness and display mode are applied at frame boundaries, and the border can be drawn off, solid, blinking or chasing.
module vga_border_gen #(
    parameter int CW          = 10,
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int RATE_FRAMES = 30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic [1:0]    mode,
    input  logic [3:0]    thick_in,
    input  logic          thick_ld,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          walls,
    output logic [3:0]    wall_id,
    output logic          frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FW      = (RATE_FRAMES > 1) ? $clog2(RATE_FRAMES) : 1;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [FW-1:0] F_LAST   = FW'(RATE_FRAMES - 1);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_CHASE = 2'd3
    } mode_t;

    localparam logic [1:0] SIDE_LEFT   = 2'd0;
    localparam logic [1:0] SIDE_TOP    = 2'd1;
    localparam logic [1:0] SIDE_RIGHT  = 2'd2;
    localparam logic [1:0] SIDE_BOTTOM = 2'd3;

    // Chase pointer value that selects each wall_id bit, packed bit3..bit0.
    localparam logic [7:0] BIT_SIDE = {SIDE_BOTTOM, SIDE_TOP, SIDE_RIGHT, SIDE_LEFT};

    logic [CW-1:0] x_reg, y_reg, x_next, y_next;
    logic          run_reg;
    logic          hsync_reg, vsync_reg, active_reg, walls_reg, frame_tick_reg;
    logic [3:0]    wall_id_reg;
    logic [3:0]    pend_reg, thick_reg, thick_next;
    mode_t         mode_reg, mode_next;
    logic [FW-1:0] fcnt_reg, fcnt_next;
    logic          phase_reg, phase_next;
    logic [1:0]    ptr_reg, ptr_next;

    logic          boundary, tick;
    logic          hsync_next, vsync_next, active_next, walls_next;
    logic [3:0]    hits, chase_mask, wall_id_next;
    logic [CW-1:0] t_ext;

    // Scan counters; the first pix_en after reset presents (0,0) without advancing.
    always_comb begin
        x_next   = x_reg;
        y_next   = y_reg;
        boundary = 1'b0;
        tick     = 1'b0;
        if (!run_reg) begin
            x_next = '0;
            y_next = '0;
            tick   = 1'b1;
        end else if (x_reg == H_LAST) begin
            x_next = '0;
            if (y_reg == V_LAST) begin
                y_next   = '0;
                boundary = 1'b1;
                tick     = 1'b1;
            end else begin
                y_next = y_reg + 1'b1;
            end
        end else begin
            x_next = x_reg + 1'b1;
        end
    end

    // Frame-level state: shadowed thickness, mode, rate counter and step state.
    always_comb begin
        thick_next = thick_reg;
        mode_next  = mode_reg;
        fcnt_next  = fcnt_reg;
        phase_next = phase_reg;
        ptr_next   = ptr_reg;
        if (boundary) begin
            thick_next = pend_reg;
            mode_next  = mode_t'(mode);
            if (mode_t'(mode) != mode_reg) begin
                fcnt_next  = '0;
                phase_next = 1'b1;
                ptr_next   = SIDE_LEFT;
            end else if (fcnt_reg == F_LAST) begin
                fcnt_next  = '0;
                phase_next = ~phase_reg;
                ptr_next   = ptr_reg + 2'd1;
            end else begin
                fcnt_next = fcnt_reg + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chase
            assign chase_mask[gi] = (ptr_next == BIT_SIDE[2*gi +: 2]);
        end
    endgenerate

    // Pixel decode from next-state counters so outputs align with x/y.
    always_comb begin
        t_ext       = CW'(thick_next);
        hsync_next  = !((x_next >= HS_START) && (x_next < HS_END));
        vsync_next  = !((y_next >= VS_START) && (y_next < VS_END));
        active_next = (x_next < H_ACT_C) && (y_next < V_ACT_C);
        hits[0]     = x_next < t_ext;
        hits[1]     = x_next >= (H_ACT_C - t_ext);
        hits[2]     = y_next < t_ext;
        hits[3]     = y_next >= (V_ACT_C - t_ext);
        hits        = hits & {4{active_next}};
        case (mode_next)
            MODE_OFF:   wall_id_next = 4'b0000;
            MODE_SOLID: wall_id_next = hits;
            MODE_BLINK: wall_id_next = phase_next ? hits : 4'b0000;
            MODE_CHASE: wall_id_next = hits & chase_mask;
            default:    wall_id_next = 4'b0000;
        endcase
        walls_next = |wall_id_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg          <= '0;
            y_reg          <= '0;
            run_reg        <= 1'b0;
            hsync_reg      <= 1'b1;
            vsync_reg      <= 1'b1;
            active_reg     <= 1'b0;
            walls_reg      <= 1'b0;
            wall_id_reg    <= 4'b0000;
            frame_tick_reg <= 1'b0;
            pend_reg       <= 4'd9;
            thick_reg      <= 4'd9;
            mode_reg       <= MODE_SOLID;
            fcnt_reg       <= '0;
            phase_reg      <= 1'b1;
            ptr_reg        <= SIDE_LEFT;
        end else if (pix_en) begin
            x_reg          <= x_next;
            y_reg          <= y_next;
            run_reg        <= 1'b1;
            hsync_reg      <= hsync_next;
            vsync_reg      <= vsync_next;
            active_reg     <= active_next;
            walls_reg      <= walls_next;
            wall_id_reg    <= wall_id_next;
            frame_tick_reg <= tick;
            thick_reg      <= thick_next;
            mode_reg       <= mode_next;
            fcnt_reg       <= fcnt_next;
            phase_reg      <= phase_next;
            ptr_reg        <= ptr_next;
            if (thick_ld) begin
                pend_reg <= thick_in;
            end
        end else begin
            frame_tick_reg <= 1'b0;
        end
    end

    assign x          = x_reg;
    assign y          = y_reg;
    assign hsync      = hsync_reg;
    assign vsync      = vsync_reg;
    assign active     = active_reg;
    assign walls      = walls_reg;
    assign wall_id    = wall_id_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_vga_border_gen.sv
// Directed bench for vga_border_gen on a reduced 40x28 raster (32x24 visible).
// A second instance with a one-frame step rate is used for chase mode.
module tb_vga_border_gen;

    localparam int CW = 8;
    localparam int HA = 32, HF = 2, HS = 3, HB = 3;
    localparam int VA = 24, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic          clk = 1'b0;
    logic          reset, pix_en, thick_ld;
    logic [1:0]    mode;
    logic [3:0]    thick_in;
    logic [CW-1:0] x, y, x2, y2;
    logic          hsync, vsync, active, walls, frame_tick;
    logic          hsync2, vsync2, active2, walls2, frame_tick2;
    logic [3:0]    wall_id, wall_id2;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    vga_border_gen #(
        .CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .RATE_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .mode(mode),
        .thick_in(thick_in), .thick_ld(thick_ld),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync), .active(active),
        .walls(walls), .wall_id(wall_id), .frame_tick(frame_tick)
    );

    vga_border_gen #(
        .CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .RATE_FRAMES(1)
    ) dut2 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .mode(mode),
        .thick_in(thick_in), .thick_ld(thick_ld),
        .x(x2), .y(y2), .hsync(hsync2), .vsync(vsync2), .active(active2),
        .walls(walls2), .wall_id(wall_id2), .frame_tick(frame_tick2)
    );

    int         sp_x [8] = '{0, 35, 9, 8, 31, 22, 16, 31};
    int         sp_y [8] = '{0, 5, 9, 12, 12, 14, 23, 23};
    logic [3:0] sp_id[8] = '{4'b0101, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0000, 4'b1000, 4'b1010};
    logic       sp_ac[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int tx, input int ty);
        int n = 0;
        pix_en = 1'b1;
        while (!(x == tx && y == ty) && n < 2 * HT * VT) begin
            step();
            n++;
        end
        if (!(x == tx && y == ty)) begin
            checks++;
            $display("FAIL run_to: at (%0d,%0d) want (%0d,%0d)", x, y, tx, ty);
        end
    endtask

    task automatic next_frame();
        run_to(HT - 1, VT - 1);
        step();
    endtask

    task automatic test_reset();
        reset = 1'b1; pix_en = 1'b1; mode = 2'd1; thick_in = 4'd0; thick_ld = 1'b0;
        repeat (3) step();
        checks++; if (x !== 8'd0) $display("FAIL reset_x: got %0d want 0", x); else passes++;
        checks++; if (y !== 8'd0) $display("FAIL reset_y: got %0d want 0", y); else passes++;
        checks++; if (hsync !== 1'b1) $display("FAIL reset_hsync: got %b want 1", hsync); else passes++;
        checks++; if (vsync !== 1'b1) $display("FAIL reset_vsync: got %b want 1", vsync); else passes++;
        checks++; if (active !== 1'b0) $display("FAIL reset_active: got %b want 0", active); else passes++;
        checks++; if (walls !== 1'b0) $display("FAIL reset_walls: got %b want 0", walls); else passes++;
        checks++; if (wall_id !== 4'b0000) $display("FAIL reset_wall_id: got %b want 0000", wall_id); else passes++;
        checks++; if (frame_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", frame_tick); else passes++;
        reset = 1'b0;
    endtask

    // Quarter-rate pix_en over a full frame: counters, syncs, active and tick period.
    task automatic test_scan();
        int ex = 0, ey = 0, ticks = 0, t0 = 0, period = 0;
        bit first = 1'b1;
        logic eh, ev, ea, et;
        for (int c = 0; c < 5000 && ticks < 2; c++) begin
            pix_en = (c % 4 == 0);
            step();
            if (pix_en) begin
                if (!first) begin
                    if (ex == HT - 1) begin
                        ex = 0;
                        ey = (ey == VT - 1) ? 0 : ey + 1;
                    end else begin
                        ex++;
                    end
                end
                first = 1'b0;
                eh = !(ex >= HA + HF && ex < HA + HF + HS);
                ev = !(ey >= VA + VF && ey < VA + VF + VS);
                ea = (ex < HA) && (ey < VA);
                checks++; if (hsync !== eh) $display("FAIL scan_hsync: got %b want %b at x=%0d", hsync, eh, ex); else passes++;
                checks++; if (vsync !== ev) $display("FAIL scan_vsync: got %b want %b at y=%0d", vsync, ev, ey); else passes++;
                checks++; if (active !== ea) $display("FAIL scan_active: got %b want %b at (%0d,%0d)", active, ea, ex, ey); else passes++;
            end
            et = pix_en && ex == 0 && ey == 0;
            checks++; if (x !== ex[CW-1:0]) $display("FAIL scan_x: got %0d want %0d", x, ex); else passes++;
            checks++; if (y !== ey[CW-1:0]) $display("FAIL scan_y: got %0d want %0d", y, ey); else passes++;
            checks++; if (frame_tick !== et) $display("FAIL scan_tick: got %b want %b cyc %0d", frame_tick, et, c); else passes++;
            if (frame_tick) begin
                ticks++;
                if (ticks == 1) t0 = c; else period = c - t0;
            end
        end
        checks++; if (period !== 4 * HT * VT) $display("FAIL tick_period: got %0d want %0d", period, 4 * HT * VT); else passes++;
        pix_en = 1'b1;
    endtask

    task automatic test_solid();
        for (int i = 0; i < 8; i++) begin
            run_to(sp_x[i], sp_y[i]);
            checks++; if (wall_id !== sp_id[i]) $display("FAIL solid_id: got %b want %b at (%0d,%0d)", wall_id, sp_id[i], sp_x[i], sp_y[i]); else passes++;
            checks++; if (walls !== (|sp_id[i])) $display("FAIL solid_walls: got %b want %b at (%0d,%0d)", walls, |sp_id[i], sp_x[i], sp_y[i]); else passes++;
            checks++; if (active !== sp_ac[i]) $display("FAIL solid_active: got %b want %b at (%0d,%0d)", active, sp_ac[i], sp_x[i], sp_y[i]); else passes++;
        end
    endtask

    task automatic test_thickness();
        run_to(0, 10);
        thick_in = 4'd3; thick_ld = 1'b1; step(); thick_ld = 1'b0;
        run_to(5, 12);
        checks++; if (wall_id !== 4'b0001) $display("FAIL thick_hold: got %b want 0001", wall_id); else passes++;
        next_frame();
        run_to(2, 12);
        checks++; if (wall_id !== 4'b0001) $display("FAIL thick3_in: got %b want 0001", wall_id); else passes++;
        run_to(5, 12);
        checks++; if (walls !== 1'b0) $display("FAIL thick3_out: got %b want 0", walls); else passes++;
        run_to(6, 12);
        thick_in = 4'd0; thick_ld = 1'b1; step(); thick_ld = 1'b0;
        next_frame();
        checks++; if (wall_id !== 4'b0000) $display("FAIL thick0_corner: got %b want 0000", wall_id); else passes++;
        checks++; if (active !== 1'b1) $display("FAIL thick0_active: got %b want 1", active); else passes++;
        // Load landing on the boundary cycle must only take effect one frame later.
        run_to(HT - 1, VT - 1);
        thick_in = 4'd5; thick_ld = 1'b1; step(); thick_ld = 1'b0;
        checks++; if (walls !== 1'b0) $display("FAIL thick_bnd_corner: got %b want 0", walls); else passes++;
        run_to(4, 12);
        checks++; if (walls !== 1'b0) $display("FAIL thick_bnd_left: got %b want 0", walls); else passes++;
        next_frame();
        checks++; if (wall_id !== 4'b0101) $display("FAIL thick5_corner: got %b want 0101", wall_id); else passes++;
        run_to(4, 12);
        checks++; if (wall_id !== 4'b0001) $display("FAIL thick5_in: got %b want 0001", wall_id); else passes++;
        step();
        checks++; if (walls !== 1'b0) $display("FAIL thick5_out: got %b want 0 at x=%0d", walls, x); else passes++;
    endtask

    task automatic test_off();
        mode = 2'd0;
        next_frame();
        checks++; if (wall_id !== 4'b0000) $display("FAIL off_id: got %b want 0000", wall_id); else passes++;
        checks++; if (walls !== 1'b0) $display("FAIL off_walls: got %b want 0", walls); else passes++;
        checks++; if (active !== 1'b1) $display("FAIL off_active: got %b want 1", active); else passes++;
    endtask

    task automatic test_blink();
        logic e;
        mode = 2'd2;
        for (int f = 0; f < 6; f++) begin
            next_frame();
            e = ((f / 2) % 2 == 0);
            checks++; if (walls !== e) $display("FAIL blink_walls: got %b want %b frame %0d", walls, e, f); else passes++;
            checks++; if (wall_id !== (e ? 4'b0101 : 4'b0000)) $display("FAIL blink_id: got %b want %b frame %0d", wall_id, e ? 4'b0101 : 4'b0000, f); else passes++;
            checks++; if (active !== 1'b1) $display("FAIL blink_active: got %b want 1 frame %0d", active, f); else passes++;
            checks++; if (frame_tick !== 1'b1) $display("FAIL blink_tick: got %b want 1 frame %0d", frame_tick, f); else passes++;
        end
    endtask

    task automatic test_chase();
        logic [3:0] ez[5] = '{4'b0001, 4'b0100, 4'b0000, 4'b0000, 4'b0001};
        logic [3:0] ec[5] = '{4'b0000, 4'b0000, 4'b0010, 4'b1000, 4'b0000};
        mode = 2'd3;
        for (int f = 0; f < 5; f++) begin
            next_frame();
            checks++; if (wall_id2 !== ez[f]) $display("FAIL chase_origin: got %b want %b frame %0d", wall_id2, ez[f], f); else passes++;
            run_to(HA - 1, VA - 1);
            checks++; if (x2 !== 8'(HA - 1)) $display("FAIL chase_x: got %0d want %0d", x2, HA - 1); else passes++;
            checks++; if (wall_id2 !== ec[f]) $display("FAIL chase_corner: got %b want %b frame %0d", wall_id2, ec[f], f); else passes++;
            checks++; if (walls2 !== (|ec[f])) $display("FAIL chase_walls: got %b want %b frame %0d", walls2, |ec[f], f); else passes++;
        end
    endtask

    task automatic test_midreset();
        mode = 2'd1;
        run_to(20, 15);
        reset = 1'b1; step();
        checks++; if (x !== 8'd0 || y !== 8'd0) $display("FAIL mid_xy: got (%0d,%0d) want (0,0)", x, y); else passes++;
        checks++; if ({hsync, vsync, active} !== 3'b110) $display("FAIL mid_sync: got %b want 110", {hsync, vsync, active}); else passes++;
        checks++; if ({walls, wall_id, frame_tick} !== 6'b0) $display("FAIL mid_walls: got %b want 000000", {walls, wall_id, frame_tick}); else passes++;
        checks++; if ({hsync2, vsync2, active2, frame_tick2} !== 4'b1100) $display("FAIL mid_dut2: got %b want 1100", {hsync2, vsync2, active2, frame_tick2}); else passes++;
        reset = 1'b0; pix_en = 1'b0; step();
        checks++; if (x !== 8'd0 || frame_tick !== 1'b0) $display("FAIL mid_hold: got x=%0d tick=%b want x=0 tick=0", x, frame_tick); else passes++;
        pix_en = 1'b1; step();
        checks++; if (x !== 8'd0 || y !== 8'd0) $display("FAIL mid_restart: got (%0d,%0d) want (0,0)", x, y); else passes++;
        checks++; if (frame_tick !== 1'b1) $display("FAIL mid_tick: got %b want 1", frame_tick); else passes++;
        checks++; if (wall_id !== 4'b0101) $display("FAIL mid_corner: got %b want 0101", wall_id); else passes++;
        step();
        checks++; if (x !== 8'd1 || frame_tick !== 1'b0) $display("FAIL mid_adv: got x=%0d tick=%b want x=1 tick=0", x, frame_tick); else passes++;
        run_to(7, 12);
        checks++; if (wall_id !== 4'b0001) $display("FAIL mid_thick9: got %b want 0001", wall_id); else passes++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_solid();
        test_thickness();
        test_off();
        test_blink();
        test_chase();
        test_midreset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
